fp_pack_pipe: RTL and testbench

- Back end of the pipelined floating-point multiplier. It is the inverse of the operand-unpack stage.
- Takes a raw sign, a biased exponent sum and the 48-bit mantissa product of two hidden-bit mantissas.
- Normalizes, rounds to nearest-even, applies exception handling, and packs an IEEE-754 single-precision result.
- Three-stage pipeline with valid/ready flow control on both sides.

---
 rtl/fpm_pkg.sv | 55 +++++
 rtl/fp_round_rne.sv | 37 +++
 rtl/fp_pack_pipe.sv | 137 +++++++++++++
 tb/tb_fp_pack_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared constants, stage payload type and normalize helper for the
// floating-point multiplier back end.
package fpm_pkg;

  localparam int FRAC_W     = 23;
  localparam int EXP_W      = 8;
  localparam int MAN_W      = 48;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  localparam logic [32:1] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [10:1] e;
    logic [23:1] frac;
    logic        g;
    logic        r;
    logic        s;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
  } stage_t;

  // Product lies in [1,4): shift right by one when the 2^1 place is set.
  function automatic stage_t fp_normalize(
    input logic        sign,
    input logic [10:1] exp_p,
    input logic [48:1] man_p,
    input logic        zero,
    input logic        inf,
    input logic        nan
  );
    stage_t p;
    p.sign    = sign;
    p.is_nan  = nan;
    p.is_inf  = inf;
    p.is_zero = zero;
    if (man_p[48]) begin
      p.frac = man_p[47:25];
      p.g    = man_p[24];
      p.r    = man_p[23];
      p.s    = |man_p[22:1];
      p.e    = exp_p + 10'd1;
    end else begin
      p.frac = man_p[46:24];
      p.g    = man_p[23];
      p.r    = man_p[22];
      p.s    = |man_p[21:1];
      p.e    = exp_p;
    end
    return p;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a 23-bit fraction with hidden bit; a carry out of
// {1,frac} resets the fraction and bumps the exponent.
module fp_round_rne
  import fpm_pkg::*;
(
  input  logic [23:1] i_frac,
  input  logic        i_g,
  input  logic        i_r,
  input  logic        i_s,
  input  logic [10:1] i_e,
  output logic [23:1] o_frac,
  output logic [10:1] o_e
);

  logic w_up;
  logic w_carry;

  // {1,frac}+1 carries out exactly when frac is all ones; frac then wraps to 0.
  always_comb begin
    w_up    = i_g && (i_r || i_s || i_frac[1]);
    w_carry = &i_frac;
    o_frac  = i_frac;
    o_e     = i_e;
    if (w_up) begin
      o_frac = i_frac + 23'd1;
      if (w_carry) begin
        o_e = i_e + 10'd1;
      end else begin
        o_e = i_e;
      end
    end else begin
      o_frac = i_frac;
      o_e    = i_e;
    end
  end

endmodule

// File: rtl/fp_pack_pipe.sv
// Three-stage normalize / round / pack back end of the FP multiplier with
// valid/ready flow control; a downstream stall freezes every stage.
module fp_pack_pipe
  import fpm_pkg::*;
#(
  parameter int EXP_MAX = FP_EXP_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_p,
  input  logic [10:1] exp_p,
  input  logic [48:1] man_p,
  input  logic        in_zero,
  input  logic        in_inf,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:1] result,
  output logic        ovf,
  output logic        unf,
  output logic        inexact
);

  localparam logic [10:1] W_EMAX = 10'(EXP_MAX);

  logic        w_stall;
  logic        r_s1_valid;
  stage_t      r_s1;
  logic        r_s2_valid;
  stage_t      r_s2;
  stage_t      w_s2_next;
  logic [23:1] w_rnd_frac;
  logic [10:1] w_rnd_e;
  logic [32:1] w_res;
  logic        w_ovf;
  logic        w_unf;
  logic        w_inx;
  logic        r_out_valid;
  logic [32:1] r_result;
  logic        r_ovf;
  logic        r_unf;
  logic        r_inx;

  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = !w_stall;

  // Stage 1: capture and normalize the incoming beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s1       <= fp_normalize(sign_p, exp_p, man_p, in_zero, in_inf, in_nan);
    end
  end

  fp_round_rne u_round (
    .i_frac (r_s1.frac),
    .i_g    (r_s1.g),
    .i_r    (r_s1.r),
    .i_s    (r_s1.s),
    .i_e    (r_s1.e),
    .o_frac (w_rnd_frac),
    .o_e    (w_rnd_e)
  );

  // Merge the rounded fraction/exponent back into the payload.
  always_comb begin
    w_s2_next      = r_s1;
    w_s2_next.frac = w_rnd_frac;
    w_s2_next.e    = w_rnd_e;
  end

  // Stage 2: register the rounded payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2       <= w_s2_next;
    end
  end

  // Exception priority nan > inf > zero > exponent range; no denormals.
  always_comb begin
    w_res = {r_s2.sign, r_s2.e[8:1], r_s2.frac};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inx = r_s2.g | r_s2.r | r_s2.s;
    if (r_s2.is_nan) begin
      w_res = FP_QNAN;
      w_inx = 1'b0;
    end else if (r_s2.is_inf) begin
      w_res = {r_s2.sign, 8'hFF, 23'd0};
      w_inx = 1'b0;
    end else if (r_s2.is_zero) begin
      w_res = {r_s2.sign, 31'd0};
      w_inx = 1'b0;
    end else if ($signed(r_s2.e) >= $signed(W_EMAX)) begin
      w_res = {r_s2.sign, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end else if ($signed(r_s2.e) <= $signed(10'd0)) begin
      w_res = {r_s2.sign, 31'd0};
      w_unf = 1'b1;
    end else begin
      w_res = {r_s2.sign, r_s2.e[8:1], r_s2.frac};
    end
  end

  // Stage 3: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= 32'h0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inx       <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s2_valid;
      r_result    <= w_res;
      r_ovf       <= w_ovf;
      r_unf       <= w_unf;
      r_inx       <= w_inx;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign inexact   = r_inx;

endmodule

// File: tb/tb_fp_pack_pipe.sv
// Directed self-checking bench for fp_pack_pipe: single-beat vectors with
// hand-computed results, a stalled 8-beat stream and a mid-stream reset.
module tb_fp_pack_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_p;
  logic [10:1] exp_p;
  logic [48:1] man_p;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [32:1] result;
  logic        ovf;
  logic        unf;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  fp_pack_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_p    (sign_p),
    .exp_p     (exp_p),
    .man_p     (man_p),
    .in_zero   (in_zero),
    .in_inf    (in_inf),
    .in_nan    (in_nan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat; expects out_valid exactly 3 clock edges after driving it.
  task automatic run_vec(input string tag, input logic s, input logic [10:1] e,
                         input logic [48:1] m, input logic z, input logic inf,
                         input logic nan, input logic [32:1] exp_res,
                         input logic [2:0] exp_flags);
    int cnt;
    in_valid  = 1'b1;
    sign_p    = s;
    exp_p     = e;
    man_p     = m;
    in_zero   = z;
    in_inf    = inf;
    in_nan    = nan;
    out_ready = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt++;
    end while (!out_valid && cnt < 8);
    chk({tag, ".latency"}, 64'(cnt), 64'd3);
    chk({tag, ".result"}, 64'(result), 64'(exp_res));
    chk({tag, ".flags"}, 64'({ovf, unf, inexact}), 64'(exp_flags));
    in_zero = 1'b0;
    in_inf  = 1'b0;
    in_nan  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:1] got[$];
    logic [32:1] exp_stream[8];
    int sent;
    int cyc;
    int stalls;

    rst       = 1'b1;
    in_valid  = 1'b0;
    sign_p    = 1'b0;
    exp_p     = 10'd0;
    man_p     = 48'd0;
    in_zero   = 1'b0;
    in_inf    = 1'b0;
    in_nan    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.result", 64'(result), 64'h0);
    chk("reset.flags", 64'({ovf, unf, inexact}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.idle_out_valid", 64'(out_valid), 64'd0);

    run_vec("one",     1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b000);
    run_vec("sq15",    1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000);
    run_vec("tie0",    1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001);
    run_vec("tie1",    1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001);
    run_vec("above",   1'b0, 10'd127, 48'h4000_0060_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 3'b001);
    run_vec("carry",   1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001);
    run_vec("ovf",     1'b1, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 3'b100);
    run_vec("maxnorm", 1'b0, 10'd254, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 3'b000);
    run_vec("unf0",    1'b0, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b010);
    run_vec("unfneg",  1'b1, 10'h3F0, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b010);
    run_vec("minnorm", 1'b0, 10'd1,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b000);
    run_vec("nan",     1'b1, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b1, 1'b1, 32'h7FC0_0000, 3'b000);
    run_vec("inf",     1'b1, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 3'b000);
    run_vec("zero",    1'b1, 10'd127, 48'h4000_0040_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 3'b000);

    // Stream of 8 beats; consumer refuses cycles 4..6.
    for (int i = 0; i < 8; i++) begin
      exp_stream[i] = {1'b0, 8'(100 + i), 23'(i)};
    end
    sent   = 0;
    cyc    = 0;
    stalls = 0;
    while (got.size() < 8 && cyc < 60) begin
      in_valid  = (sent < 8);
      sign_p    = 1'b0;
      exp_p     = 10'(100 + sent);
      man_p     = {2'b01, 23'(sent), 23'd0};
      out_ready = !(cyc >= 4 && cyc <= 6);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("stream.stall_in_ready", 64'(in_ready), 64'd0);
        stalls++;
      end
      if (out_valid && out_ready) got.push_back(result);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream.count", 64'(got.size()), 64'd8);
    chk("stream.stall_seen", 64'(stalls), 64'd3);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk($sformatf("stream.beat%0d", i), 64'(got[i]), 64'(exp_stream[i]));
    end

    // Reset while two beats are in flight: nothing may emerge afterwards.
    in_valid = 1'b1;
    exp_p    = 10'd127;
    man_p    = 48'h4000_0000_0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.result", 64'(result), 64'h0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst.quiet%0d", i), 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
